// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              if_err;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        output if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
    );

    // Requesters plus memory macro side
    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/load-store arbiter for a single-port synchronous memory
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;
    typedef enum logic {GNT_INST = 1'b0, GNT_DATA = 1'b1} grant_t;

    state_t            state;
    state_t            state_nxt;
    grant_t            last_grant;
    logic [2:0]        cnt;

    logic              grant_valid;
    grant_t            grant_sel;
    logic [ADDR_W-1:0] sel_addr;
    logic              misaligned;
    logic [3:0]        size_mask;

    logic              if_ack_q;
    logic              if_err_q;
    logic              d_ack_q;
    logic              d_err_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [3:0]        wmask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    // last_grant doubles as the owner of the transaction in flight
    always_comb begin
        grant_valid = bus.if_req || bus.d_req;
        if (bus.if_req && bus.d_req) begin
            grant_sel = (last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
        end else begin
            grant_sel = bus.d_req ? GNT_DATA : GNT_INST;
        end
        sel_addr   = (grant_sel == GNT_DATA) ? bus.d_addr : bus.if_addr;
        misaligned = 1'b0;
        size_mask  = 4'b1111;
        if (grant_sel == GNT_INST) begin
            misaligned = (sel_addr[1:0] != 2'b00);
        end else begin
            case (bus.d_size)
                2'b00: begin
                    misaligned = 1'b0;
                    size_mask  = 4'b0001;
                end
                2'b01: begin
                    misaligned = sel_addr[0];
                    size_mask  = 4'b0011;
                end
                default: misaligned = (sel_addr[1:0] != 2'b00);
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = misaligned ? ERR : ISSUE;
            ISSUE:   state_nxt = (MEM_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt <= 3'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GNT_DATA;
            cnt        <= 3'd0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            wmask_q    <= 4'b0000;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else begin
            state    <= state_nxt;
            if_ack_q <= 1'b0;
            if_err_q <= 1'b0;
            d_ack_q  <= 1'b0;
            d_err_q  <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            wmask_q  <= 4'b0000;
            wdata_q  <= 32'd0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant_sel;
                        if (misaligned) begin
                            if (grant_sel == GNT_DATA) begin
                                d_ack_q <= 1'b1;
                                d_err_q <= 1'b1;
                            end else begin
                                if_ack_q <= 1'b1;
                                if_err_q <= 1'b1;
                            end
                        end else begin
                            mem_en_q <= 1'b1;
                            addr_q   <= {sel_addr[ADDR_W-1:2], 2'b00};
                            if (grant_sel == GNT_DATA && bus.d_we) begin
                                mem_we_q <= 1'b1;
                                wmask_q  <= size_mask << sel_addr[1:0];
                                wdata_q  <= bus.d_wdata << {sel_addr[1:0], 3'b000};
                            end
                        end
                    end
                end
                ISSUE:   cnt <= 3'(MEM_LATENCY - 1);
                WAIT:    cnt <= cnt - 3'd1;
                default: ;
            endcase
            if (state_nxt == RESP) begin
                if (last_grant == GNT_DATA) d_ack_q <= 1'b1;
                else                        if_ack_q <= 1'b1;
            end
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule
